sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Pointer/flag controller for a single-clock FIFO built on the team's simple dual-port RAM.
//  Accepts push/pop requests and drives the RAM write/read enables and addresses.
//  Generates registered full/empty, programmable almost flags, occupancy count,
//  overflow/underflow pulses and a read-data-valid strobe matched to the RAM read latency.
// PARAMETERS
//  ADDR_WIDTH  9    RAM address width; FIFO depth = 2**ADDR_WIDTH (power of two only)
//  OUTPUT_REG  1    must equal the RAM's OUTPUT_REG; read latency = 1 + OUTPUT_REG cycles
//  PROG_FULL   496  almost_full asserts when count >= PROG_FULL
//  PROG_EMPTY  16   almost_empty asserts when count <= PROG_EMPTY
// PORTS
//  clk           in   1             single clock, rising edge
//  reset         in   1             asynchronous, active-high
//  wr_en         in   1             push request
//  rd_en         in   1             pop request
//  ram_we        out  1             RAM write enable
//  ram_waddr     out  ADDR_WIDTH    RAM write address
//  ram_re        out  1             RAM read enable
//  ram_raddr     out  ADDR_WIDTH    RAM read address
//  rd_valid      out  1             RAM rdata valid this cycle
//  full          out  1             no room; writes are rejected
//  empty         out  1             no data; reads are rejected
//  almost_full   out  1             count >= PROG_FULL
//  almost_empty  out  1             count <= PROG_EMPTY
//  count         out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
//  overflow      out  1             1-cycle pulse: previous-cycle write rejected
//  underflow     out  1             1-cycle pulse: previous-cycle read rejected
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count=0, empty=1, almost_empty=1,
//    full=0, almost_full=0, overflow=0, underflow=0, rd_valid=0 and latency pipe cleared.
//  - wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty (flag values from the current cycle).
//  - ram_we = wr_ok, ram_re = rd_ok (combinational); ram_waddr/ram_raddr = low ADDR_WIDTH
//    bits of the (ADDR_WIDTH+1)-bit wr_ptr/rd_ptr registers.
//  - Pointers increment by 1 on wr_ok/rd_ok and wrap modulo 2**(ADDR_WIDTH+1).
//  - count_next = count + wr_ok - rd_ok. All flags are registered from count_next:
//    full=(count_next==2**ADDR_WIDTH), empty=(count_next==0). Flags therefore update
//    in the cycle after the access.
//  - Simultaneous wr_en & rd_en:
//    - when neither flag is set, both accepted; count unchanged.
//    - when full, the read is accepted and the write rejected (overflow pulses); full clears next cycle.
//    - when empty, the write is accepted and the read rejected (underflow pulses); empty clears next cycle.
//  - Data written at cycle N is readable (rd_ok possible) at cycle N+1; RAM has no write-read
//    bypass, so the addresses never collide on one edge while count>0.
//  - rd_valid: rd_ok delayed by 1+OUTPUT_REG cycles through a shift register; it
//    marks the cycle the RAM rdata holds the popped word. rd_valid is never asserted for a
//    rejected read.
//  - overflow = registered (wr_en & full); underflow = registered (rd_en & empty).
//  - Reset mid-operation discards contents and in-flight rd_valid pulses.
//  - Elaboration check: PROG_FULL <= 2**ADDR_WIDTH, PROG_EMPTY < PROG_FULL.
// TESTING
//  1 Reset then 8 writes (ADDR_WIDTH=4) -> ram_waddr 0..7, count=8, empty falls cycle after first write.
//  2 Fill 16 of 16 -> full=1 after 16th write. 17th wr_en -> ram_we=0, overflow=1 for one cycle.
//  3 Pop with OUTPUT_REG=1 at cycle N -> rd_valid at N+2 only; with OUTPUT_REG=0 at N+1.
//  4 Simultaneous wr_en/rd_en at count=5 for 20 cycles -> count stays 5, pointers wrap 15->0.
//    Read order matches write order.
//  5 Full + wr_en + rd_en -> read accepted, write rejected, overflow=1, count 16->15.
//    Empty + both -> write accepted, underflow=1, count 0->1.
//  6 Assert reset with 3 reads in flight -> outputs immediately at reset values, no late rd_valid.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and read-valid controller for a single-clock FIFO wrapped around a
// simple dual-port RAM with 1 + OUTPUT_REG cycles of read latency.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int OUTPUT_REG = 1,
  parameter int PROG_FULL  = 496,
  parameter int PROG_EMPTY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                LAT   = 1 + OUTPUT_REG;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] PF    = (ADDR_WIDTH+1)'(PROG_FULL);
  localparam logic [ADDR_WIDTH:0] PE    = (ADDR_WIDTH+1)'(PROG_EMPTY);

  if (PROG_FULL > 2**ADDR_WIDTH || PROG_EMPTY >= PROG_FULL ||
      OUTPUT_REG < 0 || OUTPUT_REG > 1) begin : g_param_check
    $error("sync_fifo_ctrl: illegal PROG_FULL/PROG_EMPTY/OUTPUT_REG combination");
  end

  logic                  wr_ok, rd_ok;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [LAT-1:0]        vld_q, vld_d;

  // Acceptance uses the registered flags, so a full FIFO still accepts a pop and an
  // empty FIFO still accepts a push in the same cycle.
  always_comb begin
    wr_ok    = wr_en & ~full_q;
    rd_ok    = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_ok};
    count_d  = count_q + {{ADDR_WIDTH{1'b0}}, wr_ok} - {{ADDR_WIDTH{1'b0}}, rd_ok};
    full_d   = (count_d == DEPTH);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= PF);
    aempty_d = (count_d <= PE);
    ovf_d    = wr_en & full_q;
    udf_d    = rd_en & empty_q;
    vld_d    = LAT'({vld_q, rd_ok});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      vld_q    <= vld_d;
    end
  end

  assign ram_we       = wr_ok;
  assign ram_re       = rd_ok;
  assign ram_waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_raddr    = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_valid     = vld_q[LAT-1];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a reference model of pointers/flags, a small RAM
// model driven by the DUT, and a scoreboard of written words checked on rd_valid.
module tb_sync_fifo_ctrl;
  localparam int AW = 4;
  localparam int PF = 12;
  localparam int PE = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;

  logic          ram_we, ram_re, rd_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW:0]   count;

  logic          z_we, z_re, rd_valid0, z_full, z_empty, z_af, z_ae, z_ovf, z_udf;
  logic [AW-1:0] z_waddr, z_raddr;
  logic [AW:0]   z_count;

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .OUTPUT_REG(1), .PROG_FULL(PF), .PROG_EMPTY(PE)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .OUTPUT_REG(0), .PROG_FULL(PF), .PROG_EMPTY(PE)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .ram_we(z_we), .ram_waddr(z_waddr), .ram_re(z_re), .ram_raddr(z_raddr),
    .rd_valid(rd_valid0), .full(z_full), .empty(z_empty), .almost_full(z_af),
    .almost_empty(z_ae), .count(z_count), .overflow(z_ovf), .underflow(z_udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sb[$];

  logic [7:0] mem [16];
  logic [7:0] r1, r2, wdata, wctr;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wdata;
    if (ram_re) r1 <= mem[ram_raddr];
    r2 <= r1;
  end

  logic [AW:0] m_wp, m_rp;
  int          m_cnt;
  logic        m_full, m_empty, m_af, m_ae, m_ovf, m_udf;
  logic [1:0]  vpipe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_wp = '0; m_rp = '0; m_cnt = 0;
    m_full = 1'b0; m_empty = 1'b1; m_af = 1'b0; m_ae = 1'b1;
    m_ovf = 1'b0; m_udf = 1'b0; vpipe = '0;
    sb.delete();
  endtask

  // One clock of stimulus: check the combinational RAM controls, advance the model,
  // then check every registered output after the edge.
  task automatic step(input logic w, input logic r);
    logic wok, rok;
    wr_en = w; rd_en = r;
    #1;
    wok = w & ~m_full;
    rok = r & ~m_empty;
    chk("ram_we", ram_we, wok);
    chk("ram_re", ram_re, rok);
    chk("ram_waddr", ram_waddr, m_wp[AW-1:0]);
    chk("ram_raddr", ram_raddr, m_rp[AW-1:0]);
    wdata = wctr;
    if (wok) begin
      sb.push_back(int'(wctr));
      wctr = wctr + 8'd1;
    end
    m_ovf = w & m_full;
    m_udf = r & m_empty;
    m_wp  = m_wp + (AW+1)'(wok);
    m_rp  = m_rp + (AW+1)'(rok);
    m_cnt = m_cnt + int'(wok) - int'(rok);
    m_full  = (m_cnt == 16);
    m_empty = (m_cnt == 0);
    m_af    = (m_cnt >= PF);
    m_ae    = (m_cnt <= PE);
    vpipe   = {vpipe[0], rok};
    @(posedge clk);
    #1;
    chk("count", count, m_cnt);
    chk("full", full, m_full);
    chk("empty", empty, m_empty);
    chk("almost_full", almost_full, m_af);
    chk("almost_empty", almost_empty, m_ae);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("rd_valid_lat2", rd_valid, vpipe[1]);
    chk("rd_valid_lat1", rd_valid0, vpipe[0]);
    if (vpipe[1]) begin
      chk("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) chk("rdata_order", r2, sb.pop_front());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_udf"}, underflow, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_rdv0"}, rd_valid0, 0);
    chk({tag, "_waddr"}, ram_waddr, 0);
    chk({tag, "_raddr"}, ram_raddr, 0);
  endtask

  initial begin
    reset_model();
    wctr  = 8'd0;
    wdata = 8'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    // Eight writes, then fill to full and try one more
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Full with push+pop: pop wins, push rejected
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // Steady push+pop at count 5, pointers wrap
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Drain, then pop on empty
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Empty with push+pop: push wins, pop rejected
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Reset with reads in flight
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    reset_model();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_rdv", rd_valid, 0);
      chk("rst_hold_rdv0", rd_valid0, 0);
      chk("rst_hold_count", count, 0);
    end
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
